cv32e40x_pma_gate: RTL



---
 rtl/cv32e40x_pma_gate.sv | 99 +++++++++
 1 files changed

// File: rtl/cv32e40x_pma_gate.sv
// Sequences core transactions through the PMA checker: legal requests go to the bus,
// failing ones are absorbed and answered with an in-order PMA error response.
module cv32e40x_pma_gate #(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit IS_INSTR_SIDE   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_trans_valid_i,
  output logic        core_trans_ready_o,
  input  logic [31:0] core_trans_addr_i,
  input  logic        core_trans_atomic_i,
  input  logic        core_trans_spec_i,
  output logic        core_resp_valid_o,
  output logic        core_resp_pma_err_o,
  output logic        bus_trans_valid_o,
  input  logic        bus_trans_ready_i,
  output logic [31:0] bus_trans_addr_o,
  output logic        bus_trans_bufferable_o,
  output logic        bus_trans_cacheable_o,
  input  logic        bus_resp_valid_i,
  output logic [31:0] pma_addr_o,
  output logic        pma_speculative_o,
  output logic        pma_atomic_o,
  output logic        pma_execute_o,
  input  logic        pma_err_i,
  input  logic        pma_bufferable_i,
  input  logic        pma_cacheable_i
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {IDLE, WAIT_DRAIN, ERR_RESP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          bus_hs;

  assign pma_addr_o             = core_trans_addr_i;
  assign pma_speculative_o      = core_trans_spec_i;
  assign pma_atomic_o           = IS_INSTR_SIDE ? 1'b0 : core_trans_atomic_i;
  assign pma_execute_o          = IS_INSTR_SIDE;
  assign bus_trans_addr_o       = core_trans_addr_i;
  assign bus_trans_bufferable_o = pma_bufferable_i;
  assign bus_trans_cacheable_o  = pma_cacheable_i;

  assign bus_hs = bus_trans_valid_o && bus_trans_ready_i;

  always_comb begin
    state_next          = state;
    bus_trans_valid_o   = 1'b0;
    core_trans_ready_o  = 1'b0;
    core_resp_valid_o   = 1'b0;
    core_resp_pma_err_o = 1'b0;
    case (state)
      IDLE: begin
        core_resp_valid_o = bus_resp_valid_i;
        if (core_trans_valid_i && pma_err_i) begin
          // No bus request is made here, so the only counter change is a response.
          core_trans_ready_o = 1'b1;
          if (cnt == '0 || (cnt == ONE && bus_resp_valid_i)) state_next = ERR_RESP;
          else                                                state_next = WAIT_DRAIN;
        end else begin
          bus_trans_valid_o  = core_trans_valid_i && (cnt < MAX_CNT);
          core_trans_ready_o = bus_trans_valid_o && bus_trans_ready_i;
        end
      end
      WAIT_DRAIN: begin
        core_resp_valid_o = bus_resp_valid_i;
        if (cnt == ONE && bus_resp_valid_i) state_next = ERR_RESP;
      end
      ERR_RESP: begin
        core_resp_valid_o   = 1'b1;
        core_resp_pma_err_o = 1'b1;
        state_next          = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next = cnt;
    if (bus_hs && !bus_resp_valid_i)      cnt_next = cnt + ONE;
    else if (!bus_hs && bus_resp_valid_i) cnt_next = cnt - ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

endmodule
